// File: rtl/load_store_align.sv
// Load/store alignment unit: turns CPU byte/half/word loads and stores into
// accesses async_memory supports, splitting misaligned ones into sequences.
module load_store_align #(
  parameter bit ALLOW_UNALIGNED = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [1:0]  cpu_size,
  input  logic        cpu_signed,
  input  logic        cpu_re,
  input  logic        cpu_we,
  output logic [31:0] cpu_rdata,
  output logic        stall,
  output logic        fault,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_size,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LD_HI  = 2'd1,
    ST_SEQ = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    k_q, k_d;
  logic [DW-1:0] lo_q, lo_d;

  logic [1:0]    off;
  logic [4:0]    shamt;
  logic [AW-1:0] base;
  logic [2:0]    nbytes;
  logic [1:0]    last_k;
  logic [1:0]    pass_size;
  logic          crossing;
  logic          st_misaligned;
  logic          is_st;
  logic          is_ld;

  // Truncate a right-justified load to its size and sign/zero extend it.
  function automatic logic [DW-1:0] extend_load(input logic [DW-1:0] raw,
                                                input logic [1:0]    size,
                                                input logic          sgn);
    logic [DW-1:0] res;
    case (size)
      2'd0:    res = {{24{sgn & raw[7]}}, raw[7:0]};
      2'd1:    res = {{16{sgn & raw[15]}}, raw[15:0]};
      default: res = raw;
    endcase
    return res;
  endfunction

  // Request decode: offset, size in bytes, and alignment classification.
  always_comb begin
    off       = cpu_addr[1:0];
    shamt     = {off, 3'b000};
    base      = {cpu_addr[31:2], 2'b00};
    case (cpu_size)
      2'd0:    nbytes = 3'd1;
      2'd1:    nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
    pass_size     = (cpu_size == 2'd2) ? 2'd3 : cpu_size;
    last_k        = 2'(nbytes - 3'd1);
    crossing      = (3'(off) + nbytes) > 3'd4;
    st_misaligned = (cpu_size == 2'd1) ? off[0] : (cpu_size[1] && (off != 2'd0));
    is_st         = cpu_we;
    is_ld         = cpu_re & ~cpu_we;
  end

  // Next state and combinational memory/CPU side outputs.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    lo_d      = lo_q;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_size  = pass_size;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    stall     = 1'b0;
    fault     = 1'b0;
    cpu_rdata = '0;

    case (state_q)
      IDLE: begin
        if (is_st) begin
          if (!st_misaligned) begin
            mem_we = 1'b1;
          end else if (ALLOW_UNALIGNED) begin
            // First byte of a split store goes out directly from IDLE.
            mem_size  = 2'd0;
            mem_wdata = {24'h0, cpu_wdata[7:0]};
            mem_we    = 1'b1;
            stall     = 1'b1;
            k_d       = 2'd1;
            state_d   = ST_SEQ;
          end else begin
            fault = 1'b1;
          end
        end else if (is_ld) begin
          if (!crossing) begin
            mem_re    = 1'b1;
            cpu_rdata = extend_load(mem_rdata >> shamt, cpu_size, cpu_signed);
          end else if (ALLOW_UNALIGNED) begin
            // Fetch the low word now, the high word in LD_HI.
            mem_addr = base;
            mem_size = 2'd3;
            mem_re   = 1'b1;
            stall    = 1'b1;
            lo_d     = mem_rdata;
            state_d  = LD_HI;
          end else begin
            fault = 1'b1;
          end
        end
      end

      LD_HI: begin
        mem_addr  = base + 32'd4;
        mem_size  = 2'd3;
        mem_re    = 1'b1;
        cpu_rdata = extend_load(32'({mem_rdata, lo_q} >> shamt), cpu_size, cpu_signed);
        state_d   = IDLE;
      end

      ST_SEQ: begin
        mem_addr  = cpu_addr + AW'(k_q);
        mem_size  = 2'd0;
        mem_wdata = {24'h0, cpu_wdata[{k_q, 3'b000} +: 8]};
        mem_we    = 1'b1;
        stall     = (k_q != last_k);
        if (k_q == last_k) begin
          k_d     = 2'd0;
          state_d = IDLE;
        end else begin
          k_d = k_q + 2'd1;
        end
      end

      default: begin
        state_d = IDLE;
        k_d     = 2'd0;
      end
    endcase

    // Reset silences the memory and CPU handshakes without waiting for a clock.
    if (!reset) begin
      mem_we    = 1'b0;
      mem_re    = 1'b0;
      stall     = 1'b0;
      fault     = 1'b0;
      cpu_rdata = '0;
    end
  end

  // State, store byte counter and low-word capture registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      k_q     <= 2'd0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      lo_q    <= lo_d;
    end
  end

endmodule
